// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the UART receiver's line inputs and frame result outputs.
interface uart_rx_if #(
  parameter int n = 8
);
  logic         baud_tick;
  logic         Rx_in;
  logic [n-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  modport master (
    output baud_tick, Rx_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  baud_tick, Rx_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, n data bits LSB first, one parity bit, one stop bit.
// Start bit is qualified at mid-bit; every later bit is sampled one full bit period on.
module uart_rx
  import uart_pkg::*;
#(
  parameter int   n                    = 8,
  parameter logic parity_type_even_odd = 1'b1,
  parameter int   OVERSAMPLE           = OVERSAMPLE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         baud_tick,
  input  logic         Rx_in,
  output logic [n-1:0] data_out,
  output logic         data_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(n);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (Rx_in),
    .q_o   (rx_s)
  );

  rx_state_t    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [n-1:0]  shift_q, shift_d;
  logic          par_q, par_d;
  logic          rx_prev_q;
  logic [n-1:0]  data_out_q, data_out_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          valid_q, valid_d;
  logic          exp_par;

  assign exp_par = (~parity_type_even_odd) ^ (^shift_q);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_out_d = data_out_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d         = '0;
            shift_d[bit_q] = rx_s;
            bit_d          = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = PARITY;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Results are registered here so they appear together with the valid pulse.
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            data_out_d = shift_q;
            perr_d     = (par_q != exp_par);
            ferr_d     = !rx_s;
            valid_d    = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_prev_q  <= 1'b1;
      data_out_q <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      rx_prev_q  <= rx_s;
      data_out_q <= data_out_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an even-parity and an odd-parity receiver share one serial line;
// frame results are checked against a scoreboard of expected records per receiver.
module tb_uart_rx;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic rx_line = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       perr_e;
    logic       perr_o;
    logic       ferr;
  } vec_t;

  exp_t q_e[$];
  exp_t q_o[$];
  vec_t vecs[6];

  uart_rx_if #(.n(8)) if_e ();
  uart_rx_if #(.n(8)) if_o ();

  assign if_e.baud_tick = tick;
  assign if_e.Rx_in     = rx_line;
  assign if_o.baud_tick = tick;
  assign if_o.Rx_in     = rx_line;

  uart_rx #(.n(8), .parity_type_even_odd(1'b1), .OVERSAMPLE(OS)) dut_even (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (if_e.baud_tick),
    .Rx_in      (if_e.Rx_in),
    .data_out   (if_e.data_out),
    .data_valid (if_e.data_valid),
    .parity_err (if_e.parity_err),
    .frame_err  (if_e.frame_err),
    .busy       (if_e.busy)
  );

  uart_rx #(.n(8), .parity_type_even_odd(1'b0), .OVERSAMPLE(OS)) dut_odd (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (if_o.baud_tick),
    .Rx_in      (if_o.Rx_in),
    .data_out   (if_o.data_out),
    .data_valid (if_o.data_valid),
    .parity_err (if_o.parity_err),
    .frame_err  (if_o.frame_err),
    .busy       (if_o.busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk wide, every fourth clk.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx_line = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      wait_ticks(OS);
    end
    rx_line = par;
    wait_ticks(OS);
    rx_line = stop;
    wait_ticks(OS);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr_e, input logic perr_o,
                              input logic ferr);
    exp_t e;
    e.d = d; e.perr = perr_e; e.ferr = ferr;
    q_e.push_back(e);
    e.perr = perr_o;
    q_o.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_even_valid"}, {31'd0, if_e.data_valid}, 32'd0);
    check({tag, "_even_busy"},  {31'd0, if_e.busy}, 32'd0);
    check({tag, "_odd_valid"},  {31'd0, if_o.data_valid}, 32'd0);
    check({tag, "_odd_busy"},   {31'd0, if_o.busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (if_e.data_valid) begin
      if (q_e.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL even_unexpected_valid: got data_valid data 0x%0h expected no frame",
                 if_e.data_out);
      end else begin
        exp_t e;
        e = q_e.pop_front();
        check("even_data", {24'd0, if_e.data_out}, {24'd0, e.d});
        check("even_parity_err", {31'd0, if_e.parity_err}, {31'd0, e.perr});
        check("even_frame_err", {31'd0, if_e.frame_err}, {31'd0, e.ferr});
      end
    end
    if (if_o.data_valid) begin
      if (q_o.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL odd_unexpected_valid: got data_valid data 0x%0h expected no frame",
                 if_o.data_out);
      end else begin
        exp_t e;
        e = q_o.pop_front();
        check("odd_data", {24'd0, if_o.data_out}, {24'd0, e.d});
        check("odd_parity_err", {31'd0, if_o.parity_err}, {31'd0, e.perr});
        check("odd_frame_err", {31'd0, if_o.frame_err}, {31'd0, e.ferr});
      end
    end
  end

  initial begin
    //          data   par   stop  perr_e perr_o ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0,  1'b1,  1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1,  1'b0,  1'b0};
    vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0,  1'b1,  1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0,  1'b1,  1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1,  1'b0,  1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 1'b1,  1'b0,  1'b1};

    reset = 1'b1;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_even_data", {24'd0, if_e.data_out}, 32'd0);
    check("reset_even_perr", {31'd0, if_e.parity_err}, 32'd0);
    check("reset_even_ferr", {31'd0, if_e.frame_err}, 32'd0);
    check("reset_odd_data", {24'd0, if_o.data_out}, 32'd0);
    reset = 1'b0;
    wait_ticks(2 * OS);

    for (int v = 0; v < 6; v++) begin
      expect_frame(vecs[v].data, vecs[v].perr_e, vecs[v].perr_o, vecs[v].ferr);
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      rx_line = 1'b1;
      wait_ticks(OS);
    end
    check("table_even_drained", q_e.size(), 32'd0);
    check("table_odd_drained", q_o.size(), 32'd0);

    // Stop bit low, then line held low: exactly one frame, no retrigger.
    expect_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(3 * OS);
    check_idle_outputs("held_low");
    check("held_low_even_drained", q_e.size(), 32'd0);
    rx_line = 1'b1;
    wait_ticks(2 * OS);

    // False start: low for 5 ticks.
    rx_line = 1'b0;
    wait_ticks(2);
    check("false_start_busy", {31'd0, if_e.busy}, 32'd1);
    wait_ticks(3);
    rx_line = 1'b1;
    wait_ticks(4);
    check_idle_outputs("false_start");
    check("hold_even_data", {24'd0, if_e.data_out}, 32'h3C);
    check("hold_even_ferr", {31'd0, if_e.frame_err}, 32'd1);
    check("hold_odd_perr", {31'd0, if_o.parity_err}, 32'd1);
    wait_ticks(2 * OS);

    // Reset during data bit 3 of 0x55, then a clean 0x81 frame.
    rx_line = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rx_line = (8'h55 >> i) & 8'h01;
      wait_ticks(OS);
    end
    rx_line = 1'b0;
    wait_ticks(OS / 2);
    check("mid_frame_busy", {31'd0, if_o.busy}, 32'd1);
    reset = 1'b1;
    rx_line = 1'b1;
    repeat (6) @(negedge clk);
    check_idle_outputs("mid_reset");
    check("mid_reset_even_data", {24'd0, if_e.data_out}, 32'd0);
    reset = 1'b0;
    wait_ticks(2 * OS);
    expect_frame(8'h81, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(OS);
    check("after_reset_even_drained", q_e.size(), 32'd0);
    check("after_reset_odd_drained", q_o.size(), 32'd0);

    // Back-to-back frames with no idle gap between stop and next start.
    expect_frame(8'h00, 1'b1, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_ticks(OS);
    check("b2b_even_drained", q_e.size(), 32'd0);
    check("b2b_odd_drained", q_o.size(), 32'd0);
    check_idle_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter n, 8, number of data bits per frame (n >= 2).
REQ-002 SHALL have parameter parity_type_even_odd, 1'b1, parity sense (1 even / 0 odd), matching the transmitter's encoding.
REQ-003 SHALL have parameter OVERSAMPLE, 16, baud_tick pulses per bit period (even, >= 4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-007 SHALL have port Rx_in  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port data_out  output  n  last received data word.
REQ-009 SHALL have port data_valid  output  1  one-clk pulse when a frame completes.
REQ-010 SHALL have port parity_err  output  1  parity mismatch flag for the last frame.
REQ-011 SHALL have port frame_err  output  1  stop-bit-low flag for the last frame.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL pass Rx_in through a 2-flop synchronizer, giving rx_s; all decisions use rx_s only.
REQ-014 SHALL use frame format: start bit (0), n data bits LSB first, one parity bit, one stop bit (1).
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; the oversample tick counter and bit counter advance only on baud_tick.
REQ-016 IDLE: on a falling edge of rx_s (previous 1, current 0) SHALL clear the tick counter and go to START; a line held low SHALL not retrigger.
REQ-017 START: at tick count OVERSAMPLE/2-1, if rx_s=0 SHALL clear the counters and go to DATA; otherwise SHALL return to IDLE as a false start, with no output change.
REQ-018 DATA: at tick count OVERSAMPLE-1 SHALL sample rx_s into bit position bit_cnt of the shift register, then increment bit_cnt; after sampling bit n-1 SHALL go to PARITY.
REQ-019 PARITY: at tick count OVERSAMPLE-1 SHALL capture the parity bit; expected = (~parity_type_even_odd) ^ (^data); SHALL go to STOP.
REQ-020 STOP: at tick count OVERSAMPLE-1 SHALL sample the stop bit and return to IDLE.
REQ-021 STOP sample, next clk: SHALL load data_out from the shift register, set parity_err (received != expected) and frame_err (stop=0), and pulse data_valid high for exactly one clk.
REQ-022 data_out, parity_err and frame_err SHALL hold their values until the next data_valid; data_out SHALL update even when an error flag is set.
REQ-023 After a STOP, a new start edge SHALL be accepted in the very next IDLE cycle, allowing back-to-back frames.
REQ-024 The tick counter SHALL be $clog2(OVERSAMPLE) bits and wrap to 0 after OVERSAMPLE-1; bit_cnt SHALL be $clog2(n) bits.

Reset
REQ-025 When reset=1 at a clk edge: state=IDLE, counters=0, synchronizer flops=1, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-026 Reset mid-frame SHALL abort the frame with no data_valid pulse; reception SHALL resume only on a fresh falling edge after reset deasserts.

Structure
REQ-027 Shared package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, PARITY, STOP) and the default OVERSAMPLE constant.
REQ-028 The synchronizer SHALL be a sub-module named sync_2ff (reset value 1); the FSM, counters and shift register stay in uart_rx.

Verification
REQ-029 0xA5, even parity, parity bit 0, stop 1 -> data_out=0xA5, one data_valid pulse, parity_err=0, frame_err=0.
REQ-030 0x07 with parity bit 0 (even; expected 1) -> data_out=0x07, parity_err=1, frame_err=0.
REQ-031 0x3C with stop bit 0 -> data_out=0x3C, frame_err=1; the line held low afterwards produces no further frame.
REQ-032 Rx_in low for 5 ticks, then high -> no data_valid; busy returns to 0 within OVERSAMPLE/2 ticks.
REQ-033 Reset asserted during data bit 3 of 0x55, then a full 0x81 frame -> only one data_valid, with data_out=0x81.
REQ-034 Back-to-back 0x00 then 0xFF (odd parity build) with no idle gap -> two data_valid pulses, values in order, no error flags.
